// File: rtl/frame_capture_pkg.sv
// Shared constants and FSM encoding for the single-frame capture controller.
// Default window sits on the visible VGA area, downscaled to 160x120.
package frame_capture_pkg;

    localparam int DEF_H_START       = 143;
    localparam int DEF_V_START       = 34;
    localparam int DEF_H_RES         = 160;
    localparam int DEF_V_RES         = 120;
    localparam int DEF_SETTLE_FRAMES = 5;
    localparam int DEF_ADDR_W        = 15;
    localparam int FRAME_PIXELS      = DEF_H_RES * DEF_V_RES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_READY
    } cap_state_t;

endpackage

// File: rtl/vsync_sof_detect.sv
// Synchronizes an active-low VSync, emits a one-cycle start-of-frame pulse on
// its falling edge and keeps a free-running 8-bit frame counter.
module vsync_sof_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_n,
    output logic       sof,
    output logic [7:0] frame_count
);

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the delayed copy for edge detect
    logic [2:0] sync_q, sync_d;
    logic       sof_q, sof_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[1:0], vsync_n};
        sof_d  = sync_q[2] & ~sync_q[1];
        cnt_d  = sof_q ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sof_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            sof_q  <= sof_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sof         = sof_q;
    assign frame_count = cnt_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Arms, settles and captures one windowed frame into the frame buffer, then
// hands the single memory port to the pupil-search reader.
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int H_START       = DEF_H_START,
    parameter int V_START       = DEF_V_START,
    parameter int H_RES         = DEF_H_RES,
    parameter int V_RES         = DEF_V_RES,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic              iVSync,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    input  logic [9:0]        iPixel,
    input  logic              iRdReq,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic              oRdGrant,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [7:0]        oMemData,
    output logic              oMemWE,
    output logic              oReady,
    output logic              oStopCapture,
    output logic              oBusy,
    output logic [7:0]        oFrameCount
);

    cap_state_t        state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [7:0]        settle_inc;
    logic              we_q, we_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    logic              sof;
    logic              in_win;
    logic [ADDR_W-1:0] x_off, y_off, cap_addr;
    logic              unused_pix_lsbs;

    assign unused_pix_lsbs = ^iPixel[1:0];

    vsync_sof_detect u_sof (
        .clk         (iCLK),
        .rst         (iRST),
        .vsync_n     (iVSync),
        .sof         (sof),
        .frame_count (oFrameCount)
    );

    always_comb begin
        in_win   = (iX >= 13'(H_START)) && (iX < 13'(H_START + H_RES)) &&
                   (iY >= 13'(V_START)) && (iY < 13'(V_START + V_RES));
        x_off    = ADDR_W'(iX - 13'(H_START));
        y_off    = ADDR_W'(iY - 13'(V_START));
        cap_addr = x_off + ADDR_W'(H_RES) * y_off;
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        settle_inc = settle_q + 8'd1;
        case (state_q)
            ST_IDLE: if (iStart) begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: if (sof) begin
                settle_d = settle_inc;
                if (settle_inc == 8'(SETTLE_FRAMES)) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: if (sof) state_d = ST_CAPTURE;
            ST_CAPTURE:  if (sof) state_d = ST_READY;
            ST_READY: if (iStart) begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (iAbort) state_d = ST_IDLE;
    end

    // Writer owns the port whenever capturing; reader is locked out from the
    // edge that enters CAPTURE, so no grant ever overlaps a capture cycle.
    always_comb begin
        we_d    = (state_q == ST_CAPTURE) && !iAbort && in_win;
        addr_d  = we_d ? cap_addr : iRdAddr;
        data_d  = iPixel[9:2];
        grant_d = iRdReq && !we_d && (state_d != ST_CAPTURE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            we_q     <= 1'b0;
            grant_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            we_q     <= we_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign oMemWE       = we_q;
    assign oRdGrant     = grant_q;
    assign oMemAddr     = addr_q;
    assign oMemData     = data_q;
    assign oReady       = (state_q == ST_READY);
    assign oStopCapture = (state_q == ST_READY);
    assign oBusy        = (state_q == ST_SETTLE) || (state_q == ST_WAIT_SOF) ||
                          (state_q == ST_CAPTURE);

endmodule
